// File: rtl/ff_timestep_ctrl_if.sv
// Scheduler FIFO pop interface between the timestep controller (master) and
// the AER input scheduler FIFO (slave).
//
// Handshake: SCHED_DATA_OUT is valid whenever SCHED_EMPTY is 0. Driving
// CTRL_SCHED_POP_N low for one cycle consumes the head entry at that clock
// edge. The master issues at most one pop per event.
interface ff_timestep_ctrl_if #(
  parameter int AER_IN_CORE_WIDTH = 12
);
  logic                         SCHED_EMPTY;
  logic [AER_IN_CORE_WIDTH-1:0] SCHED_DATA_OUT;
  logic                         CTRL_SCHED_POP_N;

  modport master (
    input  SCHED_EMPTY,
    input  SCHED_DATA_OUT,
    output CTRL_SCHED_POP_N
  );

  modport slave (
    output SCHED_EMPTY,
    output SCHED_DATA_OUT,
    input  CTRL_SCHED_POP_N
  );
endinterface

// File: rtl/ff_timestep_ctrl.sv
// Spike-event sequencer for the FF/STDP core: pops AER events, sweeps
// integrate/fire over all post-neuron words, and counts timesteps per sample.
module ff_timestep_ctrl #(
  parameter int TIME_STEP            = 8,
  parameter int OUTPUT_NEURON        = 256,
  parameter int POST_NEUR_PARALLEL   = 4,
  parameter int POST_WORD_ADDR_WIDTH = 6,
  parameter int PRE_NEUR_ADDR_WIDTH  = 10,
  parameter int AER_IN_CORE_WIDTH    = 12,
  parameter int SYN_ARRAY_ADDR_WIDTH = 16,
  parameter int TS_WIDTH             = 3
) (
  input  logic                            CLK,
  input  logic                            RSTN,
  input  logic                            START,
  ff_timestep_ctrl_if.master              sched,
  output logic                            SYN_RD_EN,
  output logic [SYN_ARRAY_ADDR_WIDTH-1:0] SYN_ADDR,
  output logic [POST_WORD_ADDR_WIDTH-1:0] POST_WORD_ADDR,
  output logic                            NEUR_INTEG_EN,
  output logic                            NEUR_FIRE_EN,
  output logic [TS_WIDTH-1:0]             TS_IDX,
  output logic                            BUSY,
  output logic                            DONE,
  output logic [2:0]                      STATE_DBG
);

  localparam int WORDS = OUTPUT_NEURON / POST_NEUR_PARALLEL;
  localparam logic [POST_WORD_ADDR_WIDTH-1:0] LAST_WORD = POST_WORD_ADDR_WIDTH'(WORDS - 1);
  localparam logic [TS_WIDTH-1:0]             LAST_TS   = TS_WIDTH'(TIME_STEP - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_EV = 3'd1,
    POP     = 3'd2,
    INTEG   = 3'd3,
    FIRE    = 3'd4,
    NEXT_TS = 3'd5,
    DONE_ST = 3'd6
  } state_t;

  state_t                           state;
  logic [AER_IN_CORE_WIDTH-1:0]     ev;
  logic [POST_WORD_ADDR_WIDTH-1:0]  w;
  logic                             pop_n;

  logic [1:0]                       ev_virt;
  logic [PRE_NEUR_ADDR_WIDTH-1:0]   ev_addr;

  assign ev_virt = ev[AER_IN_CORE_WIDTH-1 -: 2];
  assign ev_addr = ev[PRE_NEUR_ADDR_WIDTH-1:0];

  // WORDS is a power of two, so addr*WORDS + w is a plain concatenation.
  function automatic logic [SYN_ARRAY_ADDR_WIDTH-1:0] syn_word(
    input logic [PRE_NEUR_ADDR_WIDTH-1:0]  a,
    input logic [POST_WORD_ADDR_WIDTH-1:0] wi
  );
    return SYN_ARRAY_ADDR_WIDTH'({a, wi});
  endfunction

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state         <= IDLE;
      ev            <= '0;
      w             <= '0;
      pop_n         <= 1'b1;
      SYN_RD_EN     <= 1'b0;
      SYN_ADDR      <= '0;
      NEUR_INTEG_EN <= 1'b0;
      NEUR_FIRE_EN  <= 1'b0;
      TS_IDX        <= '0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            state  <= WAIT_EV;
            TS_IDX <= '0;
            BUSY   <= 1'b1;
          end
        end
        WAIT_EV: begin
          if (!sched.SCHED_EMPTY) begin
            ev    <= sched.SCHED_DATA_OUT;
            pop_n <= 1'b0;
            state <= POP;
          end
        end
        POP: begin
          pop_n <= 1'b1;
          w     <= '0;
          case (ev_virt)
            2'b00: begin
              state         <= INTEG;
              SYN_RD_EN     <= 1'b1;
              NEUR_INTEG_EN <= 1'b1;
              SYN_ADDR      <= syn_word(ev_addr, '0);
            end
            2'b01: begin
              state        <= FIRE;
              NEUR_FIRE_EN <= 1'b1;
            end
            default: state <= WAIT_EV;
          endcase
        end
        INTEG: begin
          if (w == LAST_WORD) begin
            state         <= WAIT_EV;
            w             <= '0;
            SYN_RD_EN     <= 1'b0;
            NEUR_INTEG_EN <= 1'b0;
            SYN_ADDR      <= '0;
          end else begin
            w        <= w + POST_WORD_ADDR_WIDTH'(1);
            SYN_ADDR <= syn_word(ev_addr, w + POST_WORD_ADDR_WIDTH'(1));
          end
        end
        FIRE: begin
          if (w == LAST_WORD) begin
            state        <= NEXT_TS;
            w            <= '0;
            NEUR_FIRE_EN <= 1'b0;
          end else begin
            w <= w + POST_WORD_ADDR_WIDTH'(1);
          end
        end
        NEXT_TS: begin
          if (TS_IDX == LAST_TS) begin
            state <= DONE_ST;
            DONE  <= 1'b1;
          end else begin
            TS_IDX <= TS_IDX + TS_WIDTH'(1);
            state  <= WAIT_EV;
          end
        end
        DONE_ST: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sched.CTRL_SCHED_POP_N = pop_n;
  assign POST_WORD_ADDR         = w;
  assign STATE_DBG              = state;

endmodule

// File: tb/tb_ff_timestep_ctrl.sv
// Directed bench for ff_timestep_ctrl: the scheduler FIFO is modelled by the
// driver tasks, one task per scenario, outputs sampled on the falling edge.
module tb_ff_timestep_ctrl;

  logic        CLK;
  logic        RSTN;
  logic        START;
  logic        SYN_RD_EN;
  logic [15:0] SYN_ADDR;
  logic [5:0]  POST_WORD_ADDR;
  logic        NEUR_INTEG_EN;
  logic        NEUR_FIRE_EN;
  logic [2:0]  TS_IDX;
  logic        BUSY;
  logic        DONE;
  logic [2:0]  STATE_DBG;

  int checks = 0;
  int errors = 0;

  ff_timestep_ctrl_if #(.AER_IN_CORE_WIDTH(12)) sched_bus ();

  ff_timestep_ctrl dut (
    .CLK            (CLK),
    .RSTN           (RSTN),
    .START          (START),
    .sched          (sched_bus.master),
    .SYN_RD_EN      (SYN_RD_EN),
    .SYN_ADDR       (SYN_ADDR),
    .POST_WORD_ADDR (POST_WORD_ADDR),
    .NEUR_INTEG_EN  (NEUR_INTEG_EN),
    .NEUR_FIRE_EN   (NEUR_FIRE_EN),
    .TS_IDX         (TS_IDX),
    .BUSY           (BUSY),
    .DONE           (DONE),
    .STATE_DBG      (STATE_DBG)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic pulse_start();
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Presents one event at the FIFO head and expects it popped after one cycle.
  task automatic push_and_pop(input logic [11:0] ev, input string name);
    int n;
    @(negedge CLK);
    sched_bus.SCHED_DATA_OUT = ev;
    sched_bus.SCHED_EMPTY    = 1'b0;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (sched_bus.CTRL_SCHED_POP_N !== 1'b0 && n < 8);
    checks++;
    if (sched_bus.CTRL_SCHED_POP_N !== 1'b0 || n != 1) begin
      errors++;
      $display("FAIL %s pop_latency: got %0d cycles pop_n=%b, want 1 cycle pop_n=0",
               name, n, sched_bus.CTRL_SCHED_POP_N);
    end
    sched_bus.SCHED_EMPTY = 1'b1;
    @(negedge CLK);
    checks++;
    if (sched_bus.CTRL_SCHED_POP_N !== 1'b1) begin
      errors++;
      $display("FAIL %s pop_one_cycle: got pop_n=%b want 1", name, sched_bus.CTRL_SCHED_POP_N);
    end
  endtask

  // Checks the 64-cycle integrate sweep; current negedge is word 0.
  task automatic check_integ(input int addr, input bit start_mid, input string name);
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (SYN_RD_EN !== 1'b1 || NEUR_INTEG_EN !== 1'b1 || NEUR_FIRE_EN !== 1'b0 ||
          POST_WORD_ADDR !== 6'(i) || SYN_ADDR !== 16'(addr * 64 + i) ||
          sched_bus.CTRL_SCHED_POP_N !== 1'b1 || BUSY !== 1'b1) begin
        errors++;
        $display("FAIL %s integ_w%0d: got rd=%b integ=%b fire=%b post=%0d syn=%0d pop_n=%b busy=%b want 1 1 0 %0d %0d 1 1",
                 name, i, SYN_RD_EN, NEUR_INTEG_EN, NEUR_FIRE_EN, POST_WORD_ADDR, SYN_ADDR,
                 sched_bus.CTRL_SCHED_POP_N, BUSY, i, addr * 64 + i);
      end
      if (start_mid && i == 10) START = 1'b1;
      if (start_mid && i == 11) START = 1'b0;
      @(negedge CLK);
    end
    checks++;
    if (SYN_RD_EN !== 1'b0 || NEUR_INTEG_EN !== 1'b0 || NEUR_FIRE_EN !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL %s integ_end: got rd=%b integ=%b fire=%b busy=%b want 0 0 0 1",
               name, SYN_RD_EN, NEUR_INTEG_EN, NEUR_FIRE_EN, BUSY);
    end
  endtask

  // One marker: fire sweep, NEXT_TS, then either TS increment or DONE.
  task automatic do_marker(input int ts_before, input bit last);
    push_and_pop(12'h400, "marker");
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (NEUR_FIRE_EN !== 1'b1 || SYN_RD_EN !== 1'b0 || NEUR_INTEG_EN !== 1'b0 ||
          POST_WORD_ADDR !== 6'(i) || TS_IDX !== 3'(ts_before)) begin
        errors++;
        $display("FAIL marker_ts%0d fire_w%0d: got fire=%b rd=%b integ=%b post=%0d ts=%0d want 1 0 0 %0d %0d",
                 ts_before, i, NEUR_FIRE_EN, SYN_RD_EN, NEUR_INTEG_EN, POST_WORD_ADDR, TS_IDX, i, ts_before);
      end
      @(negedge CLK);
    end
    checks++;
    if (NEUR_FIRE_EN !== 1'b0 || DONE !== 1'b0 || TS_IDX !== 3'(ts_before)) begin
      errors++;
      $display("FAIL marker_ts%0d next_ts: got fire=%b done=%b ts=%0d want 0 0 %0d",
               ts_before, NEUR_FIRE_EN, DONE, TS_IDX, ts_before);
    end
    @(negedge CLK);
    if (last) begin
      checks++;
      if (DONE !== 1'b1 || BUSY !== 1'b1 || TS_IDX !== 3'd7) begin
        errors++;
        $display("FAIL done_pulse: got done=%b busy=%b ts=%0d want 1 1 7", DONE, BUSY, TS_IDX);
      end
      @(negedge CLK);
      checks++;
      if (DONE !== 1'b0 || BUSY !== 1'b0 || TS_IDX !== 3'd7) begin
        errors++;
        $display("FAIL done_after: got done=%b busy=%b ts=%0d want 0 0 7", DONE, BUSY, TS_IDX);
      end
    end else begin
      checks++;
      if (TS_IDX !== 3'(ts_before + 1) || DONE !== 1'b0 || BUSY !== 1'b1) begin
        errors++;
        $display("FAIL ts_incr: got ts=%0d done=%b busy=%b want %0d 0 1",
                 TS_IDX, DONE, BUSY, ts_before + 1);
      end
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (sched_bus.CTRL_SCHED_POP_N !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0 ||
        SYN_RD_EN !== 1'b0 || NEUR_INTEG_EN !== 1'b0 || NEUR_FIRE_EN !== 1'b0 ||
        TS_IDX !== 3'd0 || SYN_ADDR !== 16'd0 || POST_WORD_ADDR !== 6'd0) begin
      errors++;
      $display("FAIL %s: got pop_n=%b busy=%b done=%b rd=%b integ=%b fire=%b ts=%0d syn=%0d post=%0d want 1 0 0 0 0 0 0 0 0",
               name, sched_bus.CTRL_SCHED_POP_N, BUSY, DONE, SYN_RD_EN, NEUR_INTEG_EN,
               NEUR_FIRE_EN, TS_IDX, SYN_ADDR, POST_WORD_ADDR);
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    repeat (3) @(negedge CLK);
    RSTN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check_idle("reset_idle");
    end
  endtask

  task automatic test_spike();
    pulse_start();
    checks++;
    if (BUSY !== 1'b1 || TS_IDX !== 3'd0) begin
      errors++;
      $display("FAIL start_busy: got busy=%b ts=%0d want 1 0", BUSY, TS_IDX);
    end
    push_and_pop({2'b00, 10'd5}, "spike5");
    check_integ(5, 1'b0, "spike5");
  endtask

  task automatic test_marker();
    do_marker(0, 1'b0);
  endtask

  task automatic test_full_sample();
    for (int t = 1; t < 8; t++) begin
      repeat (2) @(negedge CLK);
      do_marker(t, t == 7);
    end
  endtask

  task automatic test_discard_and_start_ignore();
    pulse_start();
    push_and_pop({2'b10, 10'd3}, "discard");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (SYN_RD_EN !== 1'b0 || NEUR_INTEG_EN !== 1'b0 || NEUR_FIRE_EN !== 1'b0 ||
          BUSY !== 1'b1 || sched_bus.CTRL_SCHED_POP_N !== 1'b1) begin
        errors++;
        $display("FAIL discard_quiet_%0d: got rd=%b integ=%b fire=%b busy=%b pop_n=%b want 0 0 0 1 1",
                 i, SYN_RD_EN, NEUR_INTEG_EN, NEUR_FIRE_EN, BUSY, sched_bus.CTRL_SCHED_POP_N);
      end
      @(negedge CLK);
    end
    push_and_pop({2'b00, 10'd1}, "spike1");
    check_integ(1, 1'b1, "spike1_start_mid");
    checks++;
    if (TS_IDX !== 3'd0) begin
      errors++;
      $display("FAIL start_ignored_ts: got ts=%0d want 0", TS_IDX);
    end
  endtask

  task automatic test_mid_reset();
    push_and_pop({2'b00, 10'd2}, "spike2");
    repeat (20) @(negedge CLK);
    checks++;
    if (POST_WORD_ADDR !== 6'd20 || SYN_ADDR !== 16'd148) begin
      errors++;
      $display("FAIL pre_reset_w: got post=%0d syn=%0d want 20 148", POST_WORD_ADDR, SYN_ADDR);
    end
    RSTN = 1'b0;
    #1;
    check_idle("async_reset");
    sched_bus.SCHED_DATA_OUT = {2'b00, 10'd7};
    sched_bus.SCHED_EMPTY    = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check_idle("post_reset_no_pop");
    end
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    checks++;
    if (sched_bus.CTRL_SCHED_POP_N !== 1'b0) begin
      errors++;
      $display("FAIL pop_after_start: got pop_n=%b want 0", sched_bus.CTRL_SCHED_POP_N);
    end
    sched_bus.SCHED_EMPTY = 1'b1;
    @(negedge CLK);
    check_integ(7, 1'b0, "spike7_after_reset");
  endtask

  initial begin
    RSTN                     = 1'b0;
    START                    = 1'b0;
    sched_bus.SCHED_EMPTY    = 1'b1;
    sched_bus.SCHED_DATA_OUT = '0;
    test_reset();
    test_spike();
    test_marker();
    test_full_sample();
    test_discard_and_start_ignore();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ff_timestep_ctrl.md
Name: ff_timestep_ctrl

Overview:
- Sequences the spike-event datapath of the FF/STDP core.
- Pops AER events from the input scheduler FIFO and sweeps each pre-synaptic event across all post-neuron synapse words (integrate).
- On an end-of-timestep marker, runs a fire/leak sweep over all post-neuron words.
- Repeats for TIME_STEP timesteps, then reports completion; it is the single owner of the scheduler pop interface.

Parameters:
- TIME_STEP, 8, timesteps per sample.
- OUTPUT_NEURON, 256, post-neuron count.
- POST_NEUR_PARALLEL, 4, post neurons per word; WORDS = OUTPUT_NEURON/POST_NEUR_PARALLEL = 64.
- POST_WORD_ADDR_WIDTH, 6, clog2(WORDS).
- PRE_NEUR_ADDR_WIDTH, 10, pre-neuron address width.
- AER_IN_CORE_WIDTH, 12, event width = 2 + PRE_NEUR_ADDR_WIDTH.
- SYN_ARRAY_ADDR_WIDTH, 16, synapse array word address width.
- TS_WIDTH, 3, clog2(TIME_STEP).

Ports:
- CLK  in  1  clock.
- RSTN  in  1  async active-low reset.
- START  in  1  one-cycle pulse: begin a sample; ignored unless IDLE.
- SCHED_EMPTY  in  1  scheduler FIFO empty.
- SCHED_DATA_OUT  in  AER_IN_CORE_WIDTH  FIFO head {virt[1:0], addr}, valid while ~SCHED_EMPTY.
- CTRL_SCHED_POP_N  out  1  active-low pop to scheduler.
- SYN_RD_EN  out  1  synapse word read strobe.
- SYN_ADDR  out  SYN_ARRAY_ADDR_WIDTH  synapse word address.
- POST_WORD_ADDR  out  POST_WORD_ADDR_WIDTH  post-neuron word index.
- NEUR_INTEG_EN  out  1  integrate strobe for POST_WORD_ADDR.
- NEUR_FIRE_EN  out  1  fire/leak strobe for POST_WORD_ADDR.
- TS_IDX  out  TS_WIDTH  current timestep.
- BUSY  out  1  high in any state except IDLE.
- DONE  out  1  one-cycle pulse at sample end.

Behaviour:
- Reset (RSTN=0, async, any state): state IDLE; CTRL_SCHED_POP_N=1; SYN_RD_EN, NEUR_INTEG_EN, NEUR_FIRE_EN, BUSY, DONE = 0; SYN_ADDR, POST_WORD_ADDR, TS_IDX, event register = 0. Mid-operation reset abandons the sweep; no pop is issued.
- All outputs are Moore-decoded from registered state and counters; there is no combinational input-to-output path.
- States: IDLE, WAIT_EV, POP, INTEG, FIRE, NEXT_TS, DONE_ST.
- IDLE: START=1 -> WAIT_EV, TS_IDX=0.
- WAIT_EV: SCHED_EMPTY=1 -> stay, POP_N stays 1. SCHED_EMPTY=0 -> latch SCHED_DATA_OUT into ev, go to POP.
- POP: exactly one cycle, CTRL_SCHED_POP_N=0. Next state by ev.virt:
  - 2'b00 spike -> INTEG.
  - 2'b01 timestep marker -> FIRE.
  - 2'b10/2'b11 -> discard, back to WAIT_EV.
- INTEG: word counter w runs 0..WORDS-1, one word per cycle.
  - SYN_RD_EN=1, NEUR_INTEG_EN=1, POST_WORD_ADDR=w.
  - SYN_ADDR = ev.addr*WORDS + w, truncated to SYN_ARRAY_ADDR_WIDTH.
  - After w=WORDS-1 -> WAIT_EV, w cleared.
- FIRE: w runs 0..WORDS-1 with NEUR_FIRE_EN=1, SYN_RD_EN=0. After w=WORDS-1 -> NEXT_TS.
- NEXT_TS (1 cycle): if TS_IDX==TIME_STEP-1 -> DONE_ST; else TS_IDX+1 -> WAIT_EV.
- DONE_ST (1 cycle): DONE=1, BUSY=1 -> IDLE. TS_IDX holds until the next START.
- Latency: SCHED_EMPTY falls in WAIT_EV at cycle n -> POP_N low at n+1 -> first INTEG word at n+2. Per spike cost = WORDS+2 cycles; per marker = WORDS+3 cycles.
- Only one pop per POP state; SCHED_EMPTY is not sampled in POP/INTEG/FIRE. Events pushed during a sweep wait in the FIFO.
- START while BUSY is ignored. Events present before START are not popped until WAIT_EV.

Test Plan:
- Reset, then hold idle 10 cycles -> POP_N=1, BUSY=0, all strobes 0, TS_IDX=0.
- START; push {00,10'd5} -> POP_N low 1 cycle; 64 INTEG cycles with SYN_ADDR 320..383 and POST_WORD_ADDR 0..63; then back to WAIT_EV.
- Push {01,0} marker -> 64 FIRE cycles with POST_WORD_ADDR 0..63 and SYN_RD_EN=0; TS_IDX 0->1.
- Push 8 markers (empty FIFO in between) -> TS_IDX 0..7; DONE pulses once after the 8th fire sweep; BUSY falls the next cycle; TS_IDX=7.
- Push {10,3} then {00,1} -> first event popped with no strobes; second integrates SYN_ADDR 64..127. A START pulse mid-INTEG causes no state change.
- Assert RSTN low mid-INTEG at w=20 -> all outputs reset immediately; after release, state is IDLE and no pop occurs before START.
